// File: rtl/ext_pipe_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ext_pkg
// Brief   : Shared mode codes and skid-buffer state encodings for ext_pipe_unit.
// Revision: 1.0 - initial release
// ============================================================================
package ext_pkg;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;
    localparam logic [1:0] EXT_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/ext_pipe_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : ext_pipe_unit_if
// Brief   : Input/output handshake bundle of the extender pipeline.
// Revision: 1.0 - initial release
// ============================================================================
interface ext_pipe_unit_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             err_mode;

    modport slave (
        input  flush, in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, err_mode
    );

    modport master (
        output flush, in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, err_mode
    );
endinterface
`default_nettype wire

// File: rtl/ext_pipe_unit_core.sv
`default_nettype none
// ============================================================================
// Module  : ext_core
// Brief   : Combinational zero/sign/upper extension of one field, plus an
//           illegal-mode flag. Upper placement exists only with EXT_UPPER_EN.
// Revision: 1.0 - initial release
// ============================================================================
module ext_core
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  data,
    output logic [OUT_W-1:0] result,
    output logic             illegal
);

    always_comb begin
        result  = {{(OUT_W-IN_W){1'b0}}, data};
        illegal = 1'b0;
        case (mode)
            EXT_ZERO: ;
            EXT_SIGN: result = {{(OUT_W-IN_W){data[IN_W-1]}}, data};
`ifdef EXT_UPPER_EN
            EXT_UPPER: result = {data, {(OUT_W-IN_W){1'b0}}};
`else
            // Without the shifter, mode 10 falls back to zero extension.
            EXT_UPPER: illegal = 1'b1;
`endif
            EXT_RSVD: illegal = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ext_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module  : ext_pipe_unit
// Brief   : Pipelined immediate extender with 2-entry skid buffer (head+skid).
//           Optional macro EXT_UPPER_EN enables mode 10 upper placement.
// Revision: 1.0 - initial release
// ============================================================================
module ext_pipe_unit
    import ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    ext_pipe_unit_if.slave bus
);

    buf_state_t       r_state;
    buf_state_t       w_state_nxt;
    logic [OUT_W-1:0] r_head;
    logic [OUT_W-1:0] r_skid;
    logic [OUT_W-1:0] w_head_nxt;
    logic [OUT_W-1:0] w_skid_nxt;
    logic [OUT_W-1:0] w_result;
    logic             w_illegal;
    logic             r_err;
    logic             w_in_xfer;
    logic             w_out_xfer;

    // Extension happens before buffering so both slots hold final results.
    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .mode    (bus.in_mode),
        .data    (bus.in_data),
        .result  (w_result),
        .illegal (w_illegal)
    );

    assign bus.in_ready  = (r_state != ST_TWO) & ~rst;
    assign bus.out_valid = (r_state != ST_EMPTY);
    assign bus.out_data  = r_head;
    assign bus.err_mode  = r_err;

    assign w_in_xfer  = bus.in_valid & bus.in_ready;
    assign w_out_xfer = bus.out_valid & bus.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_skid_nxt  = r_skid;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = ST_ONE;
                    w_head_nxt  = w_result;
                end
            end
            ST_ONE: begin
                if (w_in_xfer && !w_out_xfer) begin
                    w_state_nxt = ST_TWO;
                    w_skid_nxt  = w_result;
                end else if (w_out_xfer && !w_in_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end else if (w_in_xfer && w_out_xfer) begin
                    w_head_nxt  = w_result;
                end
            end
            ST_TWO: begin
                if (w_out_xfer) begin
                    w_state_nxt = ST_ONE;
                    w_head_nxt  = r_skid;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (bus.flush) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_head  <= w_head_nxt;
            r_skid  <= w_skid_nxt;
            // A beat discarded by flush never counts as accepted.
            r_err   <= r_err | (w_in_xfer & w_illegal & ~bus.flush);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ext_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_ext_pipe_unit
// Brief   : Self-checking bench for ext_pipe_unit against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ext_pipe_unit;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
`ifdef EXT_UPPER_EN
    localparam int MAX_LEGAL = 2;
`else
    localparam int MAX_LEGAL = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    ext_pipe_unit_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    ext_pipe_unit #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [OUT_W-1:0] q[$];
    logic             exp_err = 1'b0;
    logic             last_rdy;
    logic             last_ov;
    logic [OUT_W-1:0] last_od;
    logic             last_err;

    function automatic logic [OUT_W-1:0] ref_ext(input int mode, input int unsigned d);
        int unsigned r;
        r = d;
        if (mode == 1 && d >= 32768) r = d + 32'hFFFF_0000;
`ifdef EXT_UPPER_EN
        if (mode == 2) r = d * 65536;
`endif
        return r;
    endfunction

    function automatic bit ref_illegal(input int mode);
        return (mode > MAX_LEGAL);
    endfunction

    task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check outputs against the model, then advance the model.
    task automatic step(input logic v, input int m, input logic [IN_W-1:0] d,
                        input logic ordy, input logic fl);
        bit acc;
        bit pop;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_mode   = 2'(m);
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #1;
        last_rdy = bus.in_ready;
        last_ov  = bus.out_valid;
        last_od  = bus.out_data;
        last_err = bus.err_mode;
        chk("in_ready",  {31'b0, bus.in_ready},  {31'b0, q.size() < 2});
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, q.size() > 0});
        if (q.size() > 0) chk("out_data", bus.out_data, q[0]);
        chk("err_mode", {31'b0, bus.err_mode}, {31'b0, exp_err});
        acc = v && (q.size() < 2);
        pop = (q.size() > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(ref_ext(m, d));
                if (ref_illegal(m)) exp_err = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        exp_err = 1'b0;
        #1;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_data",  bus.out_data, 32'd0);
        chk("rst_err_mode",  {31'b0, bus.err_mode}, 32'd0);
        chk("post_rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int accepted;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 2'b00;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // Basic sign / zero extension with one-cycle latency.
        step(1'b1, 1, 16'h8001, 1'b1, 1'b0);
        step(1'b1, 0, 16'h8001, 1'b1, 1'b0);
        chk("sign_8001", last_od, 32'hFFFF_8001);
        step(1'b0, 0, 16'h0000, 1'b1, 1'b0);
        chk("zero_8001", last_od, 32'h0000_8001);
`ifdef EXT_UPPER_EN
        step(1'b1, 2, 16'h1234, 1'b1, 1'b0);
        step(1'b0, 0, 16'h0000, 1'b1, 1'b0);
        chk("upper_1234", last_od, 32'h1234_0000);
`endif

        // Stall: fill both slots, then drain in order.
        step(1'b1, 1, 16'h0001, 1'b0, 1'b0);
        step(1'b1, 1, 16'h0002, 1'b0, 1'b0);
        step(1'b1, 1, 16'h0003, 1'b0, 1'b0);
        chk("full_in_ready", {31'b0, last_rdy}, 32'd0);
        chk("stall_head", last_od, 32'h1);
        step(1'b0, 0, 16'h0000, 1'b1, 1'b0);
        chk("drain_first", last_od, 32'h1);
        step(1'b0, 0, 16'h0000, 1'b1, 1'b0);
        chk("drain_second", last_od, 32'h2);
        chk("drain_in_ready", {31'b0, last_rdy}, 32'd1);
        step(1'b0, 0, 16'h0000, 1'b1, 1'b0);

        // Full throughput with legal random modes.
        accepted = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, $urandom_range(0, MAX_LEGAL), 16'($urandom), 1'b1, 1'b0);
            if (last_rdy) accepted++;
        end
        chk("throughput", 32'(accepted), 32'd100);
        step(1'b0, 0, 16'h0000, 1'b1, 1'b0);

        // Flush while full, with a beat presented in the flush cycle.
        step(1'b1, 0, 16'h000A, 1'b0, 1'b0);
        step(1'b1, 0, 16'h000B, 1'b0, 1'b0);
        step(1'b1, 0, 16'h000C, 1'b0, 1'b1);
        step(1'b0, 0, 16'h0000, 1'b1, 1'b0);
        chk("flush_out_valid", {31'b0, last_ov}, 32'd0);
        chk("flush_in_ready",  {31'b0, last_rdy}, 32'd1);

        // Reserved mode: zero-extended result and sticky error through flush.
        chk("err_clear_before", {31'b0, last_err}, 32'd0);
        step(1'b1, 3, 16'h8001, 1'b1, 1'b0);
        step(1'b0, 0, 16'h0000, 1'b1, 1'b0);
        chk("rsvd_result", last_od, 32'h0000_8001);
        chk("rsvd_err", {31'b0, last_err}, 32'd1);
        step(1'b0, 0, 16'h0000, 1'b1, 1'b1);
        step(1'b0, 0, 16'h0000, 1'b1, 1'b0);
        chk("err_after_flush", {31'b0, last_err}, 32'd1);
        do_reset();
`ifndef EXT_UPPER_EN
        step(1'b1, 2, 16'h8001, 1'b1, 1'b0);
        step(1'b0, 0, 16'h0000, 1'b1, 1'b0);
        chk("upper_off_result", last_od, 32'h0000_8001);
        chk("upper_off_err", {31'b0, last_err}, 32'd1);
        do_reset();
`endif

        // Random traffic: all modes, random backpressure and occasional flush.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3), 16'($urandom),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
        end
        repeat (3) step(1'b0, 0, 16'h0000, 1'b1, 1'b0);

        // Reset in mid-operation drops buffered beats.
        step(1'b1, 1, 16'h1111, 1'b0, 1'b0);
        step(1'b1, 1, 16'h2222, 1'b0, 1'b0);
        do_reset();
        step(1'b0, 0, 16'h0000, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
